// File: rtl/bt_sched_pkg.sv
// Shared constants for the baseband slot scheduler: state encoding, grant
// indices and the packet-length to continuation-slot lookup.
package bt_sched_pkg;

  localparam int unsigned HOLD_W = 3;
  localparam int unsigned GNT_W  = 3;

  localparam int unsigned GNT_SCO = 0;
  localparam int unsigned GNT_ACL = 1;
  localparam int unsigned GNT_INQ = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TX      = 2'd1;
  localparam logic [1:0] ST_RX      = 2'd2;
  localparam logic [1:0] ST_TX_HOLD = 2'd3;

  // 1-slot -> 0, 3-slot -> 2, 5-slot -> 4 extra slots; illegal code acts as 1-slot
  function automatic logic [HOLD_W-1:0] len_to_hold(input logic [1:0] len);
    case (len)
      2'd1:    return HOLD_W'(2);
      2'd2:    return HOLD_W'(4);
      default: return HOLD_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/slot_sched_if.sv
// Slot timing, requester handshake and radio-enable bundle of the scheduler.
interface slot_sched_if;
  import bt_sched_pkg::*;

  logic              tslot_p;
  logic              sco_req;
  logic              acl_req;
  logic              inq_req;
  logic [1:0]        acl_len;
  logic [1:0]        inq_len;
  logic [GNT_W-1:0]  gnt_p;
  logic              tx_en;
  logic              rx_en;
  logic              slot_start_p;
  logic              sco_miss_p;
  logic [HOLD_W-1:0] hold_cnt;

  modport master (
    output tslot_p, sco_req, acl_req, inq_req, acl_len, inq_len,
    input  gnt_p, tx_en, rx_en, slot_start_p, sco_miss_p, hold_cnt
  );

  modport slave (
    input  tslot_p, sco_req, acl_req, inq_req, acl_len, inq_len,
    output gnt_p, tx_en, rx_en, slot_start_p, sco_miss_p, hold_cnt
  );

endinterface

// File: rtl/slot_sched_sco_resv_cnt.sv
// SCO reservation: slot-pair modulo counter and reserved-slot compare.
module sco_resv_cnt
  import bt_sched_pkg::*;
#(
  parameter int unsigned TSCO_W = 3
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              adv_p,
  input  logic              own_tx,
  input  logic              sco_en,
  input  logic [TSCO_W-1:0] tsco,
  input  logic [TSCO_W-1:0] dsco,
  output logic              sco_slot_c
);

  logic [TSCO_W-1:0] sco_cnt_q;
  logic [TSCO_W-1:0] sco_cnt_d;
  logic [TSCO_W-1:0] cnt_inc;

  // compare uses the count before this slot's increment
  assign sco_slot_c = sco_en & own_tx & (sco_cnt_q == dsco);

  // advance once per own-TX slot start, wrap at tsco, clear while disabled
  always_comb begin
    cnt_inc   = sco_cnt_q + TSCO_W'(1);
    sco_cnt_d = sco_cnt_q;
    if (!sco_en) begin
      sco_cnt_d = '0;
    end else if (adv_p && own_tx) begin
      sco_cnt_d = (cnt_inc >= tsco) ? '0 : cnt_inc;
    end
  end

  // counter register
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      sco_cnt_q <= '0;
    end else begin
      sco_cnt_q <= sco_cnt_d;
    end
  end

endmodule

// File: rtl/slot_sched.sv
// Per-slot TX/RX scheduler: decides TX/RX/continuation at every slot
// boundary, arbitrates SCO > ACL > inquiry/page and aborts on resync.
module slot_sched
  import bt_sched_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned TSCO_W   = 3
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic [27:0]       BTCLK,
  input  logic              resync_p,
  input  logic              regi_sched_en,
  input  logic              regi_master,
  input  logic              regi_sco_en,
  input  logic [TSCO_W-1:0] regi_tsco,
  input  logic [TSCO_W-1:0] regi_dsco,
  slot_sched_if.slave       bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0]        state_q, state_d;
  logic [GNT_W-1:0]  gnt_p_q, gnt_p_d;
  logic              tx_en_q, tx_en_d;
  logic              rx_en_q, rx_en_d;
  logic              slot_start_p_q, slot_start_p_d;
  logic              sco_miss_p_q, sco_miss_p_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic              own_tx_c;
  logic              adv_c;
  logic              sco_slot_c;
  logic              unused_btclk_c;

  assign own_tx_c       = regi_master ? ~BTCLK[1] : BTCLK[1];
  assign adv_c          = slot_start_p_q & ~resync_p;
  assign unused_btclk_c = ^{BTCLK[27:2], BTCLK[0]};

  function automatic logic [HOLD_W-1:0] clamp_hold(input logic [HOLD_W-1:0] h);
    return (h > HOLD_MAX) ? HOLD_MAX : h;
  endfunction

  sco_resv_cnt #(.TSCO_W(TSCO_W)) u_sco_resv_cnt (
    .clk_6M     (clk_6M),
    .rstz       (rstz),
    .adv_p      (adv_c),
    .own_tx     (own_tx_c),
    .sco_en     (regi_sco_en),
    .tsco       (regi_tsco),
    .dsco       (regi_dsco),
    .sco_slot_c (sco_slot_c)
  );

  // slot decision: resync abort, disable, hold continuation or arbitration
  always_comb begin
    state_d        = state_q;
    gnt_p_d        = '0;
    tx_en_d        = tx_en_q;
    rx_en_d        = rx_en_q;
    hold_cnt_d     = hold_cnt_q;
    sco_miss_p_d   = 1'b0;
    slot_start_p_d = bus.tslot_p & ~resync_p;

    if (resync_p) begin
      state_d    = ST_IDLE;
      tx_en_d    = 1'b0;
      rx_en_d    = 1'b0;
      hold_cnt_d = '0;
    end else if (slot_start_p_q) begin
      if (!regi_sched_en) begin
        state_d    = ST_IDLE;
        tx_en_d    = 1'b0;
        rx_en_d    = 1'b0;
        hold_cnt_d = '0;
      end else begin
        case (state_q)
          ST_TX_HOLD: begin
            // multi-slot packet continues; never preempted
            hold_cnt_d   = hold_cnt_q - HOLD_W'(1);
            tx_en_d      = 1'b1;
            rx_en_d      = 1'b0;
            sco_miss_p_d = sco_slot_c;
            state_d      = (hold_cnt_q == HOLD_W'(1)) ? ST_TX : ST_TX_HOLD;
          end
          default: begin
            hold_cnt_d = '0;
            if (own_tx_c) begin
              state_d = ST_TX;
              rx_en_d = 1'b0;
              tx_en_d = 1'b1;
              if (sco_slot_c && bus.sco_req) begin
                gnt_p_d[GNT_SCO] = 1'b1;
              end else if (bus.acl_req) begin
                gnt_p_d[GNT_ACL] = 1'b1;
                hold_cnt_d       = clamp_hold(len_to_hold(bus.acl_len));
              end else if (bus.inq_req) begin
                gnt_p_d[GNT_INQ] = 1'b1;
                hold_cnt_d       = clamp_hold(len_to_hold(bus.inq_len));
              end else begin
                tx_en_d = 1'b0;
              end
              if (hold_cnt_d != '0) begin
                state_d = ST_TX_HOLD;
              end
            end else begin
              state_d = ST_RX;
              tx_en_d = 1'b0;
              rx_en_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q        <= ST_IDLE;
      gnt_p_q        <= '0;
      tx_en_q        <= 1'b0;
      rx_en_q        <= 1'b0;
      slot_start_p_q <= 1'b0;
      sco_miss_p_q   <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      gnt_p_q        <= gnt_p_d;
      tx_en_q        <= tx_en_d;
      rx_en_q        <= rx_en_d;
      slot_start_p_q <= slot_start_p_d;
      sco_miss_p_q   <= sco_miss_p_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign bus.gnt_p        = gnt_p_q;
  assign bus.tx_en        = tx_en_q;
  assign bus.rx_en        = rx_en_q;
  assign bus.slot_start_p = slot_start_p_q;
  assign bus.sco_miss_p   = sco_miss_p_q;
  assign bus.hold_cnt     = hold_cnt_q;

endmodule

// File: tb/tb_slot_sched.sv
// Self-checking bench for slot_sched with a slot-level packet model.
module tb_slot_sched;

  logic        clk_6M = 1'b0;
  logic        rstz;
  logic [27:0] btclk;
  logic        resync_p;
  logic        sched_en;
  logic        master;
  logic        sco_en;
  logic [2:0]  tsco;
  logic [2:0]  dsco;

  always #5 clk_6M = ~clk_6M;

  slot_sched_if bus_if();

  slot_sched #(.MAX_HOLD(4), .TSCO_W(3)) dut (
    .clk_6M        (clk_6M),
    .rstz          (rstz),
    .BTCLK         (btclk),
    .resync_p      (resync_p),
    .regi_sched_en (sched_en),
    .regi_master   (master),
    .regi_sco_en   (sco_en),
    .regi_tsco     (tsco),
    .regi_dsco     (dsco),
    .bus           (bus_if)
  );

  int checks;
  int failures;

  // model: slots still owed to the current packet, SCO slot-pair counter
  int m_left;
  int m_sco;

  // {gnt[2:0], tx, rx, hold[2:0], miss}
  logic [8:0] exp_v;
  logic [8:0] obs_v;
  logic       obs_start;
  logic       obs_quiet_after;

  function automatic int slots_of(input logic [1:0] len);
    return (len == 2'd1) ? 3 : (len == 2'd2) ? 5 : 1;
  endfunction

  task automatic model_step(input logic s, input logic a, input logic i,
                            input logic [1:0] al, input logic [1:0] il);
    logic own, sco_slot, any;
    logic [2:0] g;
    int pkt;
    own      = master ? (btclk[1] == 1'b0) : (btclk[1] == 1'b1);
    sco_slot = sco_en && own && (m_sco == int'(dsco));
    g        = 3'b000;
    if (!sched_en) begin
      m_left = 0;
      exp_v  = 9'd0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      exp_v  = {3'b000, 1'b1, 1'b0, 3'(m_left), sco_slot};
    end else if (!own) begin
      exp_v = {3'b000, 1'b0, 1'b1, 3'b000, 1'b0};
    end else begin
      pkt = 1;
      if (sco_slot && s) g = 3'b001;
      else if (a) begin g = 3'b010; pkt = slots_of(al); end
      else if (i) begin g = 3'b100; pkt = slots_of(il); end
      m_left = pkt - 1;
      any    = (g != 3'b000);
      exp_v  = {g, any, 1'b0, 3'(m_left), 1'b0};
    end
    if (!sco_en) m_sco = 0;
    else if (own) m_sco = (m_sco + 1) % int'(tsco);
  endtask

  // one slot: boundary pulse, capture decision at t+2 and quiet pulses at t+3
  task automatic drive_slot(input logic s, input logic a, input logic i,
                            input logic [1:0] al, input logic [1:0] il);
    @(negedge clk_6M);
    btclk = btclk + 28'd2;
    bus_if.tslot_p = 1'b1;
    bus_if.sco_req = s;
    bus_if.acl_req = a;
    bus_if.inq_req = i;
    bus_if.acl_len = al;
    bus_if.inq_len = il;
    @(negedge clk_6M);
    bus_if.tslot_p = 1'b0;
    obs_start = bus_if.slot_start_p;
    @(negedge clk_6M);
    obs_v = {bus_if.gnt_p, bus_if.tx_en, bus_if.rx_en, bus_if.hold_cnt, bus_if.sco_miss_p};
    @(negedge clk_6M);
    obs_quiet_after = (bus_if.gnt_p == 3'b000) && !bus_if.sco_miss_p;
    repeat (4) @(negedge clk_6M);
  endtask

  task automatic step(input logic s, input logic a, input logic i,
                      input logic [1:0] al, input logic [1:0] il);
    drive_slot(s, a, i, al, il);
    model_step(s, a, i, al, il);
  endtask

  task automatic do_reset();
    rstz = 1'b0;
    resync_p = 1'b0;
    bus_if.tslot_p = 1'b0;
    bus_if.sco_req = 1'b0;
    bus_if.acl_req = 1'b0;
    bus_if.inq_req = 1'b0;
    bus_if.acl_len = 2'd0;
    bus_if.inq_len = 2'd0;
    sched_en = 1'b1;
    master = 1'b1;
    sco_en = 1'b0;
    tsco = 3'd1;
    dsco = 3'd0;
    btclk = 28'd2;
    repeat (2) @(negedge clk_6M);
    rstz = 1'b1;
    m_left = 0;
    m_sco = 0;
    @(negedge clk_6M);
  endtask

  task automatic test_reset();
    logic [9:0] o;
    do_reset();
    rstz = 1'b0;
    bus_if.tslot_p = 1'b1;
    bus_if.acl_req = 1'b1;
    repeat (3) @(negedge clk_6M);
    o = {bus_if.gnt_p, bus_if.tx_en, bus_if.rx_en, bus_if.slot_start_p,
         bus_if.sco_miss_p, bus_if.hold_cnt};
    checks++;
    if (o !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", o, 10'd0);
    end
    bus_if.tslot_p = 1'b0;
    bus_if.acl_req = 1'b0;
  endtask

  task automatic test_acl_single();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    checks++;
    if (obs_start !== 1'b1) begin
      failures++;
      $display("FAIL acl1_slot_start got=%b exp=1", obs_start);
    end
    checks++;
    if (obs_v !== 9'b010_1_0_000_0) begin
      failures++;
      $display("FAIL acl1_grant got=%b exp=%b", obs_v, 9'b010_1_0_000_0);
    end
    checks++;
    if (obs_quiet_after !== 1'b1) begin
      failures++;
      $display("FAIL acl1_gnt_one_cycle got=%b exp=1", obs_quiet_after);
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if (obs_v !== 9'b000_0_1_000_0) begin
      failures++;
      $display("FAIL acl1_next_rx got=%b exp=%b", obs_v, 9'b000_0_1_000_0);
    end
  endtask

  task automatic test_acl_5slot();
    logic [8:0] e;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) step(1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
      else        step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
      e = {(k == 0) ? 3'b010 : 3'b000, 1'b1, 1'b0, 3'(4 - k), 1'b0};
      checks++;
      if (obs_v !== e) begin
        failures++;
        $display("FAIL acl5_slot%0d got=%b exp=%b", k, obs_v, e);
      end
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if (obs_v !== 9'b000_0_1_000_0) begin
      failures++;
      $display("FAIL acl5_sixth_rx got=%b exp=%b", obs_v, 9'b000_0_1_000_0);
    end
  endtask

  task automatic test_sco();
    int sco_gnts;
    do_reset();
    sco_en = 1'b1;
    tsco = 3'd3;
    dsco = 3'd1;
    sco_gnts = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, 2'd0);
      if (obs_v[8:6] == 3'b001) sco_gnts++;
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL sco_slot%0d got=%b exp=%b", k, obs_v, exp_v);
      end
    end
    checks++;
    if (sco_gnts != 2) begin
      failures++;
      $display("FAIL sco_grant_count got=%0d exp=2", sco_gnts);
    end
  endtask

  task automatic test_sco_miss();
    int misses;
    do_reset();
    sco_en = 1'b1;
    tsco = 3'd3;
    dsco = 3'd1;
    misses = 0;
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, k == 1, 1'b0, 2'd2, 2'd0);
      if (obs_v[0]) misses++;
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL miss_slot%0d got=%b exp=%b", k, obs_v, exp_v);
      end
    end
    checks++;
    if (misses != 1) begin
      failures++;
      $display("FAIL miss_count got=%0d exp=1", misses);
    end
    checks++;
    if (obs_v[8:6] !== 3'b001) begin
      failures++;
      $display("FAIL miss_next_sco_grant got=%b exp=001", obs_v[8:6]);
    end
  endtask

  task automatic test_resync();
    logic [6:0] o;
    do_reset();
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    checks++;
    if (obs_v[3:1] !== 3'd3) begin
      failures++;
      $display("FAIL resync_pre_hold got=%0d exp=3", obs_v[3:1]);
    end
    @(negedge clk_6M);
    resync_p = 1'b1;
    @(negedge clk_6M);
    resync_p = 1'b0;
    o = {bus_if.gnt_p, bus_if.tx_en, bus_if.rx_en, bus_if.hold_cnt[1:0]};
    checks++;
    if (o !== 7'd0 || bus_if.hold_cnt !== 3'd0) begin
      failures++;
      $display("FAIL resync_abort got=%b hold=%0d exp=0", o, bus_if.hold_cnt);
    end
    m_left = 0;
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    checks++;
    if (obs_v !== 9'b010_1_0_000_0 || exp_v !== obs_v) begin
      failures++;
      $display("FAIL resync_resume got=%b exp=%b", obs_v, 9'b010_1_0_000_0);
    end
    // resync coinciding with the boundary swallows that decision
    @(negedge clk_6M);
    btclk = btclk + 28'd2;
    bus_if.tslot_p = 1'b1;
    bus_if.acl_req = 1'b1;
    resync_p = 1'b1;
    @(negedge clk_6M);
    bus_if.tslot_p = 1'b0;
    resync_p = 1'b0;
    checks++;
    if (bus_if.slot_start_p !== 1'b0) begin
      failures++;
      $display("FAIL resync_coincide_start got=%b exp=0", bus_if.slot_start_p);
    end
    @(negedge clk_6M);
    o = {bus_if.gnt_p, bus_if.tx_en, bus_if.rx_en, bus_if.hold_cnt[1:0]};
    checks++;
    if (o !== 7'd0) begin
      failures++;
      $display("FAIL resync_coincide_outputs got=%b exp=0", o);
    end
    repeat (5) @(negedge clk_6M);
    m_left = 0;
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL resync_after_coincide got=%b exp=%b", obs_v, exp_v);
    end
  endtask

  task automatic test_slave();
    logic [8:0] e;
    do_reset();
    master = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
      e = btclk[1] ? 9'b100_1_0_000_0 : 9'b000_0_1_000_0;
      checks++;
      if (obs_v !== e || obs_v !== exp_v) begin
        failures++;
        $display("FAIL slave_slot%0d got=%b exp=%b", k, obs_v, e);
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    sched_en = 1'b0;
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    checks++;
    if (obs_v !== 9'd0 || exp_v !== 9'd0) begin
      failures++;
      $display("FAIL disable_off got=%b exp=%b", obs_v, 9'd0);
    end
    sched_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    checks++;
    if (obs_v !== exp_v) begin
      failures++;
      $display("FAIL disable_reenable got=%b exp=%b", obs_v, exp_v);
    end
  endtask

  task automatic test_random();
    logic ps, pa, pi;
    logic [1:0] al, il;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      master = 1'($urandom_range(0, 1));
      sco_en = 1'($urandom_range(0, 1));
      tsco = 3'($urandom_range(1, 6));
      dsco = 3'($urandom_range(0, int'(tsco) - 1));
      ps = 1'b0; pa = 1'b0; pi = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (!ps) ps = ($urandom_range(0, 2) == 0);
        if (!pa) pa = ($urandom_range(0, 3) == 0);
        if (!pi) pi = ($urandom_range(0, 3) == 0);
        al = 2'($urandom_range(0, 3));
        il = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) sched_en = ~sched_en;
        step(ps, pa, pi, al, il);
        checks++;
        if (obs_v !== exp_v) begin
          failures++;
          $display("FAIL rand_r%0d_s%0d got=%b exp=%b", r, k, obs_v, exp_v);
        end
        checks++;
        if (obs_start !== 1'b1 || obs_quiet_after !== 1'b1) begin
          failures++;
          $display("FAIL rand_pulses_r%0d_s%0d start=%b quiet=%b exp=1,1",
                   r, k, obs_start, obs_quiet_after);
        end
        checks++;
        if (obs_v[5] && obs_v[4]) begin
          failures++;
          $display("FAIL rand_txrx_excl_r%0d_s%0d got=11 exp=not both", r, k);
        end
        if (exp_v[6]) ps = 1'b0;
        if (exp_v[7]) pa = 1'b0;
        if (exp_v[8]) pi = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstz = 1'b0;
    test_reset();
    test_acl_single();
    test_acl_5slot();
    test_sco();
    test_sco_miss();
    test_resync();
    test_slave();
    test_disable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
